// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 32;
    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest legal starvation limit (15)
    localparam int unsigned WAIT_W           = 4;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_e;

    // Per-command tag travelling alongside the memory access
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant select for core/ext with a starvation guard: core wins by default,
// ext wins once it has waited STARVE_LIMIT consecutive cycles.
module dmem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic core_req,
    input  logic ext_req,
    output logic core_gnt_c,
    output logic ext_gnt_c,
    output logic starve_ovr_c
);

    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              starve;

    assign starve = (wait_cnt == WAIT_W'(STARVE_LIMIT));

    // Grant decision and wait counter update
    always_comb begin
        core_gnt_c   = 1'b0;
        ext_gnt_c    = 1'b0;
        starve_ovr_c = 1'b0;
        wait_cnt_nxt = wait_cnt;
        if (!rst) begin
            if (ext_req && (starve || !core_req)) begin
                ext_gnt_c    = 1'b1;
                starve_ovr_c = core_req;
            end else if (core_req) begin
                core_gnt_c = 1'b1;
            end
        end
        if (!ext_req || ext_gnt_c) begin
            wait_cnt_nxt = '0;
        end else if (!starve) begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core and an external master.
// Commands are registered toward memory; a two-stage tag pipeline routes
// each response (load data or store ack) back to its requester.
// Optional transfer/starvation counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_we,
    output logic                core_gnt,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                ext_req,
    input  logic [ADDR_W-1:0]   ext_addr,
    input  logic [DATA_W-1:0]   ext_wdata,
    input  logic [DATA_W/8-1:0] ext_we,
    output logic                ext_gnt,
    output logic                ext_rvalid,
    output logic [DATA_W-1:0]   ext_rdata,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_we,
    input  logic [DATA_W-1:0]   mem_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]         stat_core_cnt,
    output logic [31:0]         stat_ext_cnt,
    output logic [15:0]         stat_starve_cnt,
`endif
    output logic                core_stall
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic core_xfer;
    logic ext_xfer;
    logic starve_ovr;
    tag_t tag1;
    tag_t tag2;
    logic store2;

    dmem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk          (clk),
        .rst          (rst),
        .core_req     (core_req),
        .ext_req      (ext_req),
        .core_gnt_c   (core_gnt),
        .ext_gnt_c    (ext_gnt),
        .starve_ovr_c (starve_ovr)
    );

    assign core_xfer  = core_req && core_gnt;
    assign ext_xfer   = ext_req && ext_gnt;
    assign core_stall = !rst && core_req && !core_gnt;

    // Command stage: register the winner's payload toward memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= '0;
        end else begin
            mem_en <= core_xfer || ext_xfer;
            if (core_xfer) begin
                mem_addr  <= core_addr;
                mem_wdata <= core_wdata;
                mem_we    <= core_we;
            end else if (ext_xfer) begin
                mem_addr  <= ext_addr;
                mem_wdata <= ext_wdata;
                mem_we    <= ext_we;
            end else begin
                mem_we <= '0;
            end
        end
    end

    // Tag pipeline; store flag taken from the registered command one stage later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag1   <= '0;
            tag2   <= '0;
            store2 <= 1'b0;
        end else begin
            tag1.valid <= core_xfer || ext_xfer;
            tag1.owner <= ext_xfer ? OWN_EXT : OWN_CORE;
            tag2       <= tag1;
            store2     <= mem_en && (mem_we != BE_W'(0));
        end
    end

    // Response routing: data only for loads, zero for store acks and idle
    always_comb begin
        core_rvalid = tag2.valid && (tag2.owner == OWN_CORE);
        ext_rvalid  = tag2.valid && (tag2.owner == OWN_EXT);
        core_rdata  = (core_rvalid && !store2) ? mem_rdata : '0;
        ext_rdata   = (ext_rvalid && !store2) ? mem_rdata : '0;
    end

`ifdef DMEM_ARB_STATS_EN
    // Transfer and starvation-override counters, wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_core_cnt   <= '0;
            stat_ext_cnt    <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (core_xfer) begin
                stat_core_cnt <= stat_core_cnt + 32'(1);
            end
            if (ext_xfer) begin
                stat_ext_cnt <= stat_ext_cnt + 32'(1);
            end
            if (starve_ovr) begin
                stat_starve_cnt <= stat_starve_cnt + 16'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_we;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        ext_req;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_we;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata = '0;
    logic        core_stall;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_cnt;
    logic [31:0] stat_ext_cnt;
    logic [15:0] stat_starve_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] mem [logic [31:0]];

    dmem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_we     (core_we),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ext_req     (ext_req),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_we      (ext_we),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .mem_en      (mem_en),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_cnt   (stat_core_cnt),
        .stat_ext_cnt    (stat_ext_cnt),
        .stat_starve_cnt (stat_starve_cnt),
`endif
        .core_stall  (core_stall)
    );

    always #5 clk = ~clk;

    // Initial memory image for addresses never written
    function automatic logic [31:0] init_val(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1111_1111;
            32'h0000_0004: return 32'h2222_2222;
            32'h0000_0008: return 32'h3333_3333;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return 32'h0000_0000;
        endcase
    endfunction

    // Synchronous memory: read data valid the cycle after mem_en
    always @(posedge clk) begin
        if (mem_en) begin
            logic [31:0] w;
            w = mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
            if (mem_we != 4'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                end
                mem[mem_addr] = w;
            end else begin
                mem_rdata <= w;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        core_req   = 1'b1;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        core_we    = 4'h0;
        ext_req    = 1'b1;
        ext_addr   = 32'h0;
        ext_wdata  = 32'h0;
        ext_we     = 4'h0;

        // Reset state: grants and stall forced low even with requests pending
        @(negedge clk);
        check("rst_core_gnt", 32'(core_gnt), 32'd0);
        check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        check("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
        tick();
        core_req = 1'b0;
        ext_req  = 1'b0;
        rst      = 1'b0;
        tick();

        // Contention: core granted 4 cycles, then ext once, repeating
        core_req  = 1'b1;
        core_addr = 32'h0;
        ext_req   = 1'b1;
        ext_addr  = 32'h4;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("cont_core_gnt_%0d", i), 32'(core_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
            check($sformatf("cont_ext_gnt_%0d", i), 32'(ext_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("cont_stall_%0d", i), 32'(core_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
            tick();
        end
        core_req = 1'b0;
        ext_req  = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        @(negedge clk);
        check("stat_core", stat_core_cnt, 32'd8);
        check("stat_ext", stat_ext_cnt, 32'd2);
        check("stat_starve", 32'(stat_starve_cnt), 32'd2);
`endif
        tick();
        tick();
        tick();

        // Core load from 0x100
        core_req  = 1'b1;
        core_addr = 32'h100;
        core_we   = 4'h0;
        @(negedge clk);
        check("ld_core_gnt", 32'(core_gnt), 32'd1);
        check("ld_ext_gnt", 32'(ext_gnt), 32'd0);
        tick();
        core_req = 1'b0;
        @(negedge clk);
        check("ld_mem_en", 32'(mem_en), 32'd1);
        check("ld_mem_addr", mem_addr, 32'h100);
        check("ld_mem_we", 32'(mem_we), 32'd0);
        check("ld_rvalid_early", 32'(core_rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("ld_core_rvalid", 32'(core_rvalid), 32'd1);
        check("ld_core_rdata", core_rdata, 32'hDEAD_BEEF);
        check("ld_ext_rvalid", 32'(ext_rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("ld_rvalid_pulse", 32'(core_rvalid), 32'd0);
        check("ld_mem_en_idle", 32'(mem_en), 32'd0);

        // Ext store to 0x200, lower two bytes
        tick();
        ext_req   = 1'b1;
        ext_addr  = 32'h200;
        ext_wdata = 32'h1234;
        ext_we    = 4'b0011;
        @(negedge clk);
        check("st_ext_gnt", 32'(ext_gnt), 32'd1);
        tick();
        ext_req = 1'b0;
        @(negedge clk);
        check("st_mem_en", 32'(mem_en), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'b0011);
        check("st_mem_addr", mem_addr, 32'h200);
        check("st_mem_wdata", mem_wdata, 32'h1234);
        tick();
        @(negedge clk);
        check("st_ext_rvalid", 32'(ext_rvalid), 32'd1);
        check("st_ext_rdata", ext_rdata, 32'd0);
        check("st_core_rvalid", 32'(core_rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("st_rvalid_pulse", 32'(ext_rvalid), 32'd0);
        check("st_mem_we_idle", 32'(mem_we), 32'd0);

        // Back-to-back core loads 0x0, 0x4, 0x8
        tick();
        core_req  = 1'b1;
        core_addr = 32'h0;
        tick();
        core_addr = 32'h4;
        @(negedge clk);
        check("b2b_mem_addr0", mem_addr, 32'h0);
        tick();
        core_addr = 32'h8;
        @(negedge clk);
        check("b2b_rvalid0", 32'(core_rvalid), 32'd1);
        check("b2b_rdata0", core_rdata, 32'h1111_1111);
        tick();
        core_req = 1'b0;
        @(negedge clk);
        check("b2b_rvalid1", 32'(core_rvalid), 32'd1);
        check("b2b_rdata1", core_rdata, 32'h2222_2222);
        tick();
        @(negedge clk);
        check("b2b_rvalid2", 32'(core_rvalid), 32'd1);
        check("b2b_rdata2", core_rdata, 32'h3333_3333);
        tick();
        @(negedge clk);
        check("b2b_rvalid_end", 32'(core_rvalid), 32'd0);

        // Reset one cycle after a grant discards the in-flight response
        tick();
        core_req  = 1'b1;
        core_addr = 32'h100;
        tick();
        rst = 1'b1;
        #1;
        check("rmf_mem_en", 32'(mem_en), 32'd0);
        check("rmf_core_gnt", 32'(core_gnt), 32'd0);
        check("rmf_stall", 32'(core_stall), 32'd0);
        @(negedge clk);
        check("rmf_rvalid_a", 32'(core_rvalid), 32'd0);
        tick();
        @(negedge clk);
        check("rmf_rvalid_b", 32'(core_rvalid), 32'd0);
        check("rmf_ext_rvalid", 32'(ext_rvalid), 32'd0);
        tick();
        rst      = 1'b0;
        core_req = 1'b0;
        @(negedge clk);
        check("rmf_rvalid_c", 32'(core_rvalid), 32'd0);
        check("rmf_mem_en_post", 32'(mem_en), 32'd0);

        // Normal operation after reset
        tick();
        core_req  = 1'b1;
        core_addr = 32'h4;
        @(negedge clk);
        check("post_core_gnt", 32'(core_gnt), 32'd1);
        tick();
        core_req = 1'b0;
        tick();
        @(negedge clk);
        check("post_rvalid", 32'(core_rvalid), 32'd1);
        check("post_rdata", core_rdata, 32'h2222_2222);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
